serial_tx: RTL and testbench

//   Serial frame transmitter. It accepts a parallel word on a start strobe and

---
 rtl/serial_tx.sv | 128 ++++++++++++
 tb/tb_serial_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
`timescale 1ns/100ps
// Serial frame transmitter: start bit, DATA_W bits LSB first, stop bit; line idles high.
// tx/busy/done are registered; start is ignored while busy and may be accepted in the done cycle.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic              tx_nxt, busy_nxt, done_nxt;
  logic              bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      baud_cnt <= baud_cnt_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    baud_cnt_nxt = baud_cnt;
    tx_nxt       = tx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
        baud_cnt_nxt = '0;
        if (start) begin
          shift_nxt = din;
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_nxt    = DATA;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          tx_nxt       = shift[0];
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            // next bit to drive is the new LSB after the shift
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + IDX_W'(1);
            tx_nxt      = shift_nxt[0];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          state_nxt    = IDLE;
          baud_cnt_nxt = '0;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt    = IDLE;
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
`timescale 1ns/100ps
// Directed bench for serial_tx: reset, frame shape, ignored starts, back-to-back, mid-frame reset, 1-cycle bits.
module tb_serial_tx;

  logic       Clk;
  logic       rst;
  logic       start, start1;
  logic [7:0] din, din1;
  logic       tx, busy, done;
  logic       tx1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .Clk(Clk), .rst(rst), .start(start), .din(din),
    .tx(tx), .busy(busy), .done(done)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .Clk(Clk), .rst(rst), .start(start1), .din(din1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot j of a frame carrying d (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  // Called just after the negedge preceding the accepting posedge; ends on the done cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input int poke_at,
                           input logic [7:0] poke_din, input logic keep_start);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      check($sformatf("%s_tx_c%0d", tag, i), tx, frame_bit(d, i / 4));
      check($sformatf("%s_busy_c%0d", tag, i), busy, 1);
      check($sformatf("%s_done_c%0d", tag, i), done, 0);
      if (!keep_start) start = (i == poke_at);
      if (i == poke_at) din = poke_din;
    end
    @(negedge Clk);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tx_end"}, tx, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    din    = 8'h00;
    din1   = 8'h00;

    // 1: reset asserted before any clock edge
    #0.1 rst = 1'b0;
    #0.9;
    check_idle("t1_rst");
    check("t1_rst_tx1", tx1, 1);
    check("t1_rst_busy1", busy1, 0);
    check("t1_rst_done1", done1, 0);
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check_idle("t1_post");
    end

    // 2: single frame A5
    din   = 8'hA5;
    start = 1'b1;
    run_frame("t2", 8'hA5, -1, 8'h00, 1'b0);
    @(negedge Clk);
    check_idle("t2_after");

    // 3: start with FF mid-frame is ignored
    din   = 8'hA5;
    start = 1'b1;
    run_frame("t3", 8'hA5, 17, 8'hFF, 1'b0);
    repeat (4) begin
      @(negedge Clk);
      check_idle("t3_after");
    end

    // 4: start held high, back-to-back frames 3C then C3
    din   = 8'h3C;
    start = 1'b1;
    run_frame("t4a", 8'h3C, 10, 8'hC3, 1'b1);
    run_frame("t4b", 8'hC3, -1, 8'h00, 1'b0);
    @(negedge Clk);
    check_idle("t4_after");

    // 5: reset during data bit 3 of F0, then send 0F
    din   = 8'hF0;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    check("t5_pre_tx_bit3", tx, 0);
    check("t5_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check_idle("t5_abort");
    repeat (2) begin
      @(negedge Clk);
      check_idle("t5_inrst");
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check_idle("t5_release");
    end
    din   = 8'h0F;
    start = 1'b1;
    run_frame("t5b", 8'h0F, -1, 8'h00, 1'b0);
    @(negedge Clk);
    check_idle("t5_after");

    // 6: CLKS_PER_BIT=1 instance, payload 00
    din1   = 8'h00;
    start1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      start1 = 1'b0;
      check($sformatf("t6_tx_c%0d", i), tx1, (i < 9) ? 32'd0 : 32'd1);
      check($sformatf("t6_busy_c%0d", i), busy1, 1);
    end
    @(negedge Clk);
    check("t6_busy_end", busy1, 0);
    check("t6_done_pulse", done1, 1);
    check("t6_tx_end", tx1, 1);
    @(negedge Clk);
    check("t6_done_clear", done1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
